// File: rtl/fb_dma_ctrl_if.sv
// Memory-port bundle between the CPU, the DMA controller and the memory block.
// The controller sits on the master modport: it takes the CPU requests and the
// port-1 read data, and drives the memory read port 1 and the write port.
// The slave modport is the view of the surrounding system (CPU plus memory).
interface fb_dma_ctrl_if;
   logic        cpu_ren;
   logic [15:0] cpu_raddr;
   logic        cpu_wen;
   logic [15:0] cpu_waddr;
   logic [15:0] cpu_wdata;
   logic        mem_ren;
   logic [15:0] mem_raddr1;
   logic        mem_wen;
   logic [15:0] mem_waddr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata1;

   modport master (
      input  cpu_ren, cpu_raddr, cpu_wen, cpu_waddr, cpu_wdata, mem_rdata1,
      output mem_ren, mem_raddr1, mem_wen, mem_waddr, mem_wdata
   );

   modport slave (
      output cpu_ren, cpu_raddr, cpu_wen, cpu_waddr, cpu_wdata, mem_rdata1,
      input  mem_ren, mem_raddr1, mem_wen, mem_waddr, mem_wdata
   );
endinterface

// File: rtl/fb_dma_ctrl.sv
// fb_dma_ctrl: shares memory read port 1 and the write port between the CPU
// and a small fill/copy DMA engine. The CPU always wins and passes through
// combinationally; the engine only uses cycles the CPU leaves idle.
// Writes at or above IO_BASE are suppressed and flagged in dma_err.
// Build option DMA_COPY_EN: when defined, copy mode (RD/W1/CAP states and the
// hold register) is included; otherwise every transfer is a fill.
module fb_dma_ctrl #(
   parameter logic [15:0] IO_BASE = 16'hF000
) (
   input  logic          clk,
   input  logic          rst_n,
   fb_dma_ctrl_if.master mif,
   input  logic          dma_start,
   input  logic          dma_copy,
   input  logic [15:0]   dma_src,
   input  logic [15:0]   dma_dst,
   input  logic [15:0]   dma_len,
   input  logic [15:0]   dma_fill,
   output logic          dma_busy,
   output logic          dma_done,
   output logic          dma_err
);

`ifdef DMA_COPY_EN
   typedef enum logic [2:0] {
      IDLE = 3'd0, RD = 3'd1, W1 = 3'd2, CAP = 3'd3, WR = 3'd4, DONE = 3'd5
   } state_e;
`else
   typedef enum logic [2:0] {
      IDLE = 3'd0, WR = 3'd4, DONE = 3'd5
   } state_e;
`endif

   state_e      state_q, state_d;
   logic [15:0] dst_q;
   logic [15:0] cnt_q;
   logic [15:0] fill_q;
   logic        err_q;
`ifdef DMA_COPY_EN
   logic [15:0] src_q;
   logic [15:0] hold_q;
   logic        copy_q;
`else
   // Copy-only inputs have no function in a fill-only build.
   logic        unused_copy_inputs;
   assign unused_copy_inputs = ^{dma_copy, dma_src, mif.mem_rdata1};
`endif

   logic accept;     // start pulse taken this cycle
   logic wr_slot;    // engine owns the write port this cycle
   logic io_hit;     // current destination lies in the IO region
   logic last_word;  // the write in this slot finishes the transfer

   assign accept    = (state_q == IDLE) && dma_start;
   assign wr_slot   = (state_q == WR) && !mif.cpu_wen;
   assign io_hit    = (dst_q >= IO_BASE);
   assign last_word = (cnt_q == 16'd1);
   assign dma_err   = err_q;

   // State register; reset aborts any transfer in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the values from before the clock edge.
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic: CPU activity on a port stalls the state needing it.
   always_comb begin
      // NOTE: the default assignment first keeps this block free of latches.
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (dma_start) begin
               if (dma_len == 16'd0) state_d = DONE;
`ifdef DMA_COPY_EN
               else if (dma_copy)    state_d = RD;
`endif
               else                  state_d = WR;
            end
         end
`ifdef DMA_COPY_EN
         RD:  if (!mif.cpu_ren) state_d = W1;
         W1:  state_d = CAP;
         CAP: state_d = WR;
`endif
         WR: begin
            if (!mif.cpu_wen) begin
               if (last_word) state_d = DONE;
`ifdef DMA_COPY_EN
               else if (copy_q) state_d = RD;
`endif
               else           state_d = WR;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Transfer registers: load on accept, capture read data, advance per write.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: these registers are always loaded on accept before use; they are
      // cleared anyway so nothing undefined can reach the bus after reset.
      if (!rst_n) begin
         dst_q  <= '0;
         cnt_q  <= '0;
         fill_q <= '0;
         err_q  <= 1'b0;
`ifdef DMA_COPY_EN
         src_q  <= '0;
         hold_q <= '0;
         copy_q <= 1'b0;
`endif
      end else if (accept) begin
         dst_q  <= dma_dst;
         cnt_q  <= dma_len;
         fill_q <= dma_fill;
         err_q  <= 1'b0;
`ifdef DMA_COPY_EN
         src_q  <= dma_src;
         copy_q <= dma_copy;
`endif
      end else begin
`ifdef DMA_COPY_EN
         // Read data is valid two cycles after RD, i.e. exactly in CAP.
         if (state_q == CAP) hold_q <= mif.mem_rdata1;
`endif
         if (wr_slot) begin
            dst_q <= dst_q + 16'd1;
            cnt_q <= cnt_q - 16'd1;
            if (io_hit) err_q <= 1'b1;
`ifdef DMA_COPY_EN
            if (copy_q) src_q <= src_q + 16'd1;
`endif
         end
      end
   end

   // Output logic: CPU pass-through first, engine fills idle port slots.
   always_comb begin
      mif.mem_ren    = mif.cpu_ren;
      mif.mem_raddr1 = mif.cpu_ren ? mif.cpu_raddr : 16'h0000;
      mif.mem_wen    = mif.cpu_wen;
      mif.mem_waddr  = mif.cpu_wen ? mif.cpu_waddr : 16'h0000;
      mif.mem_wdata  = mif.cpu_wen ? mif.cpu_wdata : 16'h0000;
`ifdef DMA_COPY_EN
      if ((state_q == RD) && !mif.cpu_ren) begin
         mif.mem_ren    = 1'b1;
         mif.mem_raddr1 = src_q;
      end
`endif
      if (wr_slot && !io_hit) begin
         mif.mem_wen   = 1'b1;
         mif.mem_waddr = dst_q;
`ifdef DMA_COPY_EN
         mif.mem_wdata = copy_q ? hold_q : fill_q;
`else
         mif.mem_wdata = fill_q;
`endif
      end
      dma_busy = (state_q != IDLE) && (state_q != DONE);
      dma_done = (state_q == DONE);
   end

endmodule

// File: tb/tb_fb_dma_ctrl.sv
// Testbench for fb_dma_ctrl. Stimulus pushes the hand-computed memory-port
// events (DMA reads, writes, done pulses, each with its cycle number) into a
// scoreboard queue; a monitor on the falling edge pops and compares every
// event the DUT presents. Copy-mode cases follow DMA_COPY_EN.
module tb_fb_dma_ctrl;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fb_dma_ctrl_if mif ();

   logic        dma_start, dma_copy;
   logic [15:0] dma_src, dma_dst, dma_len, dma_fill;
   logic        dma_busy, dma_done, dma_err;

   fb_dma_ctrl #(.IO_BASE(16'hF000)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .mif       (mif),
      .dma_start (dma_start),
      .dma_copy  (dma_copy),
      .dma_src   (dma_src),
      .dma_dst   (dma_dst),
      .dma_len   (dma_len),
      .dma_fill  (dma_fill),
      .dma_busy  (dma_busy),
      .dma_done  (dma_done),
      .dma_err   (dma_err)
   );

   // Memory read-port model: fixed contents, data two cycles after address.
   function automatic logic [15:0] rom(input logic [15:0] a);
      case (a)
         16'h0100: return 16'h1234;
         16'h0101: return 16'h5678;
         16'h0102: return 16'h9ABC;
         default:  return 16'hDEAD;
      endcase
   endfunction

   logic [15:0] rd_pipe1 = '0;
   logic [15:0] rd_pipe2 = '0;
   always @(posedge clk) begin
      rd_pipe1 <= mif.mem_raddr1;
      rd_pipe2 <= rd_pipe1;
   end
   assign mif.mem_rdata1 = rom(rd_pipe2);

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef enum int {EV_RD = 0, EV_WR = 1, EV_DONE = 2} ev_e;
   typedef struct {
      ev_e         kind;
      int          cyc;
      logic [15:0] addr;
      logic [15:0] data;
   } ev_t;

   ev_t sb[$];
   int  checks   = 0;
   int  errors   = 0;
   int  busy_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic exp_rd(input int c, input logic [15:0] a);
      sb.push_back('{kind: EV_RD, cyc: c, addr: a, data: 16'h0000});
   endtask

   task automatic exp_wr(input int c, input logic [15:0] a, input logic [15:0] d);
      sb.push_back('{kind: EV_WR, cyc: c, addr: a, data: d});
   endtask

   task automatic exp_done(input int c);
      sb.push_back('{kind: EV_DONE, cyc: c, addr: 16'h0000, data: 16'h0000});
   endtask

   task automatic match(input ev_e kind, input logic [15:0] addr, input logic [15:0] data);
      ev_t e;
      check("sb_event_expected", (sb.size() != 0), 1'b1);
      if (sb.size() != 0) begin
         e = sb.pop_front();
         check("ev_kind", kind, e.kind);
         check("ev_cycle", cyc, e.cyc);
         if (kind != EV_DONE) check("ev_addr", addr, e.addr);
         if (kind == EV_WR)   check("ev_data", data, e.data);
      end
   endtask

   // Monitor: every DMA read, every write and every done pulse must match.
   always @(negedge clk) begin
      if (rst_n) begin
         if (dma_busy) busy_cnt++;
         if (mif.mem_ren && !mif.cpu_ren) match(EV_RD, mif.mem_raddr1, 16'h0000);
         if (mif.mem_wen) match(EV_WR, mif.mem_waddr, mif.mem_wdata);
         if (dma_done) match(EV_DONE, 16'h0000, 16'h0000);
      end
   end

   task automatic run(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Pulse a start; k is the cycle in which dma_start is high.
   task automatic start_dma(input logic cp, input logic [15:0] src, input logic [15:0] dst,
                            input logic [15:0] len, input logic [15:0] fill, output int k);
      @(posedge clk);
      #1;
      dma_copy  = cp;
      dma_src   = src;
      dma_dst   = dst;
      dma_len   = len;
      dma_fill  = fill;
      dma_start = 1'b1;
      k         = cyc;
      @(posedge clk);
      #1;
      dma_start = 1'b0;
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_busy"},  dma_busy, 1'b0);
      check({tag, "_done"},  dma_done, 1'b0);
      check({tag, "_err"},   dma_err, 1'b0);
      check({tag, "_ren"},   mif.mem_ren, 1'b0);
      check({tag, "_wen"},   mif.mem_wen, 1'b0);
      check({tag, "_raddr"}, mif.mem_raddr1, 16'h0000);
      check({tag, "_waddr"}, mif.mem_waddr, 16'h0000);
      check({tag, "_wdata"}, mif.mem_wdata, 16'h0000);
   endtask

   int k;
   int b0;

   initial begin
      mif.cpu_ren   = 1'b0;
      mif.cpu_raddr = '0;
      mif.cpu_wen   = 1'b0;
      mif.cpu_waddr = '0;
      mif.cpu_wdata = '0;
      dma_start = 1'b0;
      dma_copy  = 1'b0;
      dma_src   = '0;
      dma_dst   = '0;
      dma_len   = '0;
      dma_fill  = '0;

      // Reset values.
      run(3);
      check_idle_outputs("reset");
      rst_n = 1'b1;
      run(2);

      // CPU pass-through while idle: same-cycle, no added latency.
      exp_wr(cyc, 16'h0300, 16'hBEEF);
      mif.cpu_ren   = 1'b1;
      mif.cpu_raddr = 16'h1234;
      mif.cpu_wen   = 1'b1;
      mif.cpu_waddr = 16'h0300;
      mif.cpu_wdata = 16'hBEEF;
      #1;
      check("pass_ren", mif.mem_ren, 1'b1);
      check("pass_raddr", mif.mem_raddr1, 16'h1234);
      run(1);
      mif.cpu_ren = 1'b0;
      mif.cpu_wen = 1'b0;
      run(1);

      // Fill, no contention: 4 writes on consecutive cycles, done on the 5th.
      b0 = busy_cnt;
      start_dma(1'b0, 16'h0000, 16'hE000, 16'd4, 16'h00AA, k);
      for (int i = 0; i < 4; i++) exp_wr(k + 1 + i, 16'hE000 + 16'(i), 16'h00AA);
      exp_done(k + 5);
      run(6);
      check("fill_drained", sb.size(), 0);
      check("fill_busy_cycles", busy_cnt - b0, 4);

      // Copy (or, in a fill-only build, a copy request that behaves as fill).
      b0 = busy_cnt;
`ifdef DMA_COPY_EN
      start_dma(1'b1, 16'h0100, 16'hC000, 16'd2, 16'h7777, k);
      exp_rd(k + 1, 16'h0100);
      exp_wr(k + 4, 16'hC000, 16'h1234);
      exp_rd(k + 5, 16'h0101);
      exp_wr(k + 8, 16'hC001, 16'h5678);
      exp_done(k + 9);
      run(10);
      check("copy_drained", sb.size(), 0);
      check("copy_busy_cycles", busy_cnt - b0, 8);
`else
      start_dma(1'b1, 16'h0100, 16'hC000, 16'd2, 16'h7777, k);
      exp_wr(k + 1, 16'hC000, 16'h7777);
      exp_wr(k + 2, 16'hC001, 16'h7777);
      exp_done(k + 3);
      run(5);
      check("copy_as_fill_drained", sb.size(), 0);
      check("copy_as_fill_busy_cycles", busy_cnt - b0, 2);
`endif

      // CPU contention: CPU writes 0200 for 2 cycles, DMA write is held.
      b0 = busy_cnt;
      start_dma(1'b0, 16'h0000, 16'hE200, 16'd3, 16'h00BB, k);
      exp_wr(k + 1, 16'hE200, 16'h00BB);
      exp_wr(k + 2, 16'h0200, 16'hCAFE);
      exp_wr(k + 3, 16'h0200, 16'hCAFE);
      exp_wr(k + 4, 16'hE201, 16'h00BB);
      exp_wr(k + 5, 16'hE202, 16'h00BB);
      exp_done(k + 6);
      run(1);
      mif.cpu_wen   = 1'b1;
      mif.cpu_waddr = 16'h0200;
      mif.cpu_wdata = 16'hCAFE;
      run(2);
      mif.cpu_wen   = 1'b0;
      mif.cpu_waddr = '0;
      mif.cpu_wdata = '0;
      run(4);
      check("contend_drained", sb.size(), 0);
      check("contend_busy_cycles", busy_cnt - b0, 5);

      // IO guard: EFFF written, F000 suppressed, error flagged.
      b0 = busy_cnt;
      start_dma(1'b0, 16'h0000, 16'hEFFF, 16'd2, 16'h1357, k);
      exp_wr(k + 1, 16'hEFFF, 16'h1357);
      exp_done(k + 3);
      run(4);
      check("guard_drained", sb.size(), 0);
      check("guard_busy_cycles", busy_cnt - b0, 2);
      check("guard_err", dma_err, 1'b1);

      // Zero length: done next cycle, no writes, busy never rises, err cleared.
      b0 = busy_cnt;
      start_dma(1'b0, 16'h0000, 16'h0400, 16'd0, 16'h9999, k);
      exp_done(k + 1);
      check("len0_err_cleared", dma_err, 1'b0);
      run(3);
      check("len0_drained", sb.size(), 0);
      check("len0_busy_cycles", busy_cnt - b0, 0);

      // Wrap: FFFF suppressed (IO region), second write lands at 0000.
      b0 = busy_cnt;
      start_dma(1'b0, 16'h0000, 16'hFFFF, 16'd2, 16'h2468, k);
      exp_wr(k + 2, 16'h0000, 16'h2468);
      exp_done(k + 3);
      run(4);
      check("wrap_drained", sb.size(), 0);
      check("wrap_busy_cycles", busy_cnt - b0, 2);
      check("wrap_err", dma_err, 1'b1);

      // A second start while busy is ignored.
      b0 = busy_cnt;
      start_dma(1'b0, 16'h0000, 16'hE100, 16'd4, 16'h5555, k);
      for (int i = 0; i < 4; i++) exp_wr(k + 1 + i, 16'hE100 + 16'(i), 16'h5555);
      exp_done(k + 5);
      run(1);
      dma_dst   = 16'h0300;
      dma_len   = 16'd1;
      dma_fill  = 16'h1111;
      dma_start = 1'b1;
      run(1);
      dma_start = 1'b0;
      run(4);
      check("restart_drained", sb.size(), 0);
      check("restart_busy_cycles", busy_cnt - b0, 4);

      // Reset during word 3 of a transfer whose error flag is already set.
`ifdef DMA_COPY_EN
      start_dma(1'b1, 16'h0100, 16'hEFFF, 16'd8, 16'h0000, k);
      exp_rd(k + 1, 16'h0100);
      exp_wr(k + 4, 16'hEFFF, 16'h1234);
      exp_rd(k + 5, 16'h0101);
      exp_rd(k + 9, 16'h0102);
      run(9);
`else
      start_dma(1'b0, 16'h0000, 16'hEFFF, 16'd8, 16'h0F0F, k);
      exp_wr(k + 1, 16'hEFFF, 16'h0F0F);
      run(2);
`endif
      check("pre_reset_busy", dma_busy, 1'b1);
      check("pre_reset_err", dma_err, 1'b1);
      rst_n = 1'b0;
      #1;
      check_idle_outputs("midreset");
      run(2);
      rst_n = 1'b1;
      run(20);
      check("midreset_drained", sb.size(), 0);
      check("midreset_busy_after", dma_busy, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
